// File: rtl/eth_tx_buff_reader.sv
// Streams a frame out of the TX buffer's read port onto a valid/ready byte stream.
// Define ETH_TX_PAD_EN to zero-pad short frames up to MIN_FRAME bytes.
module eth_tx_buff_reader #(
    parameter int MIN_FRAME = 60,
    parameter int BUF_AW    = 11
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        ctrl_address,
    input  logic              ctrl_write,
    input  logic [31:0]       ctrl_writedata,
    input  logic              ctrl_read,
    output logic [31:0]       ctrl_readdata,
    output logic [BUF_AW-1:0] buf_address,
    output logic              buf_chipselect,
    output logic              buf_clken,
    input  logic [7:0]        buf_readdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              tx_sop,
    output logic              tx_eop,
    output logic              irq
);

    localparam int LW = BUF_AW + 1;
    localparam logic [LW-1:0] MAX_LEN = LW'(1) << BUF_AW;
    localparam logic [LW-1:0] MIN_LEN = LW'(MIN_FRAME);

`ifdef ETH_TX_PAD_EN
    typedef enum logic [2:0] {IDLE, PRIME, STREAM, PAD, FINISH} state_t;
`else
    typedef enum logic [2:0] {IDLE, PRIME, STREAM, FINISH} state_t;
`endif

    state_t state, state_n;

    logic [BUF_AW-1:0] base_reg;
    logic [LW-1:0]     len_reg;
    logic [15:0]       frames;
    logic              done;
    logic              err;

    logic [LW-1:0]     len_q;
    logic [LW-1:0]     total;
    logic [BUF_AW-1:0] rd_addr;
    logic [LW-1:0]     rem_rd;
    logic              rd_pend;
    logic [LW-1:0]     load_idx;

    logic [7:0]        fifo_mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        fifo_cnt;

    logic start_req, done_clr, err_clr, len_ok, busy;
    logic accept, issue, pad_load, load_en;
    logic push, pop, out_free, tx_fire, eop_fire;
    logic [2:0] occ_after;
    logic unused_wdata;

    assign start_req = ctrl_write && (ctrl_address == 2'd0) && ctrl_writedata[0];
    assign done_clr  = ctrl_write && (ctrl_address == 2'd0) && ctrl_writedata[1];
    assign err_clr   = ctrl_write && (ctrl_address == 2'd0) && ctrl_writedata[2];
    assign len_ok    = (len_reg != '0) && (len_reg <= MAX_LEN);
    assign busy      = (state != IDLE);

    assign out_free  = !tx_valid || tx_ready;
    assign push      = rd_pend;
    assign pop       = (fifo_cnt != 2'd0) && out_free;
    assign load_en   = pop || pad_load;
    assign tx_fire   = tx_valid && tx_ready;
    assign eop_fire  = tx_fire && tx_eop;

    // Bytes already committed to the skid buffer (queued or still in the RAM);
    // a new read is only launched if it can never overflow the two entries.
    assign occ_after = 3'(fifo_cnt) + 3'(rd_pend) - 3'(pop);

`ifdef ETH_TX_PAD_EN
    logic pad_short;
    assign pad_short = (len_q < MIN_LEN);
    assign total     = pad_short ? MIN_LEN : len_q;
`else
    logic [LW-1:0] unused_min;
    assign unused_min = MIN_LEN;
    assign total      = len_q;
`endif

    assign unused_wdata   = ^ctrl_writedata[31:LW];
    assign buf_address    = rd_addr;
    assign buf_clken      = issue;
    assign buf_chipselect = issue;
    assign irq            = done;

    always_ff @(posedge clk) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n  = state;
        accept   = 1'b0;
        issue    = 1'b0;
        pad_load = 1'b0;
        case (state)
            IDLE: begin
                if (start_req && len_ok) begin
                    accept  = 1'b1;
                    state_n = PRIME;
                end
            end
            PRIME: begin
                issue   = 1'b1;
                state_n = STREAM;
            end
            STREAM: begin
                issue = (rem_rd != '0) && (occ_after <= 3'd1);
                if (eop_fire)
                    state_n = FINISH;
`ifdef ETH_TX_PAD_EN
                else if ((rem_rd == '0) && pad_short)
                    state_n = PAD;
`endif
            end
`ifdef ETH_TX_PAD_EN
            PAD: begin
                // Zeros only follow once every real byte has left the skid buffer.
                pad_load = (fifo_cnt == 2'd0) && !rd_pend && out_free && (load_idx != total);
                if (eop_fire)
                    state_n = FINISH;
            end
`endif
            FINISH: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_mem[wr_ptr] <= buf_readdata;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            base_reg      <= '0;
            len_reg       <= '0;
            frames        <= '0;
            done          <= 1'b0;
            err           <= 1'b0;
            len_q         <= '0;
            rd_addr       <= '0;
            rem_rd        <= '0;
            rd_pend       <= 1'b0;
            load_idx      <= '0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            fifo_cnt      <= 2'd0;
            tx_data       <= 8'h00;
            tx_valid      <= 1'b0;
            tx_sop        <= 1'b0;
            tx_eop        <= 1'b0;
            ctrl_readdata <= '0;
        end else begin
            if (ctrl_write && (ctrl_address == 2'd1)) base_reg <= ctrl_writedata[BUF_AW-1:0];
            if (ctrl_write && (ctrl_address == 2'd2)) len_reg  <= ctrl_writedata[LW-1:0];

            done <= (state == FINISH) | (done & ~done_clr);
            err  <= (start_req && !accept) | (err & ~err_clr);
            if (state == FINISH) frames <= frames + 16'd1;

            if (accept) begin
                len_q    <= len_reg;
                rd_addr  <= base_reg;
                rem_rd   <= len_reg;
                load_idx <= '0;
            end else if (issue) begin
                rd_addr <= rd_addr + BUF_AW'(1);
                rem_rd  <= rem_rd - LW'(1);
            end
            rd_pend <= issue;

            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase

            // sop/eop are decided by position when a byte enters the output register.
            if (load_en) begin
                tx_valid <= 1'b1;
                tx_data  <= pop ? fifo_mem[rd_ptr] : 8'h00;
                tx_sop   <= (load_idx == '0);
                tx_eop   <= (load_idx == total - LW'(1));
                load_idx <= load_idx + LW'(1);
            end else if (tx_fire) begin
                tx_valid <= 1'b0;
                tx_sop   <= 1'b0;
                tx_eop   <= 1'b0;
            end

            if (ctrl_read) begin
                case (ctrl_address)
                    2'd0:    ctrl_readdata <= {29'd0, err, done, busy};
                    2'd1:    ctrl_readdata <= 32'(base_reg);
                    2'd2:    ctrl_readdata <= 32'(len_reg);
                    default: ctrl_readdata <= {16'd0, frames};
                endcase
            end else begin
                ctrl_readdata <= '0;
            end
        end
    end

endmodule
